// File: rtl/dm_timer_bridge.sv
// dm_timer_bridge
//   Single-cycle M-stage data port bridge: a word-addressed data RAM with
//   byte-enable writes and a memory-mapped countdown timer raising irq.
//
//   Ports:
//     clk            system clock, all state updates on rising edge
//     reset          synchronous, active-low
//     m_data_addr    byte address (bits [1:0] ignored for decode)
//     m_data_wdata   lane-aligned write data
//     m_data_byteen  per-byte write enable, 4'b0000 = read/idle
//     m_inst_addr    PC of the M-stage instruction (write log only)
//     m_data_rdata   combinational read data
//     irq            registered timer interrupt (level)
//
//   Build option: define DM_TIMER_BRIDGE_WRITE_LOG_EN to print every
//   accepted RAM/timer write.
module dm_timer_bridge #(
    parameter int          RAM_WORDS  = 3072,
    parameter logic [31:0] TIMER_BASE = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    input  logic [31:0] m_inst_addr,
    output logic [31:0] m_data_rdata,
    output logic        irq
);

    localparam int          AW        = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    // ---------------- decode ----------------
    logic          ram_hit, tmr_hit, ram_we, tmr_we;
    logic [AW-1:0] ram_idx;

    assign ram_hit = (m_data_addr < RAM_BYTES);
    assign tmr_hit = (m_data_addr[31:4] == TIMER_BASE[31:4]) && (m_data_addr[3:2] != 2'b11);
    assign ram_idx = m_data_addr[AW+1:2];
    assign ram_we  = ram_hit && (m_data_byteen != 4'b0000);
    assign tmr_we  = tmr_hit && (m_data_byteen == 4'b1111);

    // ---------------- data RAM ----------------
    logic [31:0] mem [RAM_WORDS];
    logic [31:0] ram_merged;

    always_comb begin
        ram_merged = mem[ram_idx];
        for (int unsigned b = 0; b < 4; b++) begin
            if (m_data_byteen[b]) ram_merged[8*b +: 8] = m_data_wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < RAM_WORDS; i++) mem[i[AW-1:0]] <= '0;
        end else if (ram_we) begin
            mem[ram_idx] <= ram_merged;
        end
    end

    // ---------------- timer ----------------
    // ctrl: [0] EN, [2:1] MODE, [3] IM
    state_t      state, state_next;
    logic [3:0]  ctrl, ctrl_next;
    logic [31:0] preset, preset_next;
    logic [31:0] count, count_next;
    logic        irq_flag, irq_flag_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
            irq      <= 1'b0;
        end else begin
            state    <= state_next;
            ctrl     <= ctrl_next;
            preset   <= preset_next;
            count    <= count_next;
            irq_flag <= irq_flag_next;
            irq      <= irq_flag_next & ctrl_next[3];
        end
    end

    always_comb begin
        state_next    = state;
        ctrl_next     = ctrl;
        preset_next   = preset;
        count_next    = count;
        irq_flag_next = irq_flag;

        // transition decisions use the pre-write ctrl
        case (state)
            IDLE: if (ctrl[0]) state_next = LOAD;
            LOAD: begin
                count_next    = preset;
                irq_flag_next = 1'b0;
                state_next    = CNT;
            end
            CNT: begin
                if (!ctrl[0]) begin
                    state_next = IDLE;
                end else if (count > 32'd1) begin
                    count_next = count - 32'd1;
                end else begin
                    count_next = '0;
                    state_next = INT;
                end
            end
            INT: begin
                irq_flag_next = 1'b1;
                if (ctrl[2:1] == 2'b01) begin
                    state_next = LOAD;
                end else begin
                    ctrl_next[0] = 1'b0;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // CPU writes applied last so they override same-cycle FSM updates
        if (tmr_we) begin
            case (m_data_addr[3:2])
                2'b00: begin
                    ctrl_next     = m_data_wdata[3:0];
                    irq_flag_next = 1'b0;
                end
                2'b01:   preset_next = m_data_wdata;
                default: ;
            endcase
        end
    end

    // ---------------- read mux ----------------
    always_comb begin
        m_data_rdata = '0;
        if (ram_hit) begin
            m_data_rdata = mem[ram_idx];
        end else if (tmr_hit) begin
            case (m_data_addr[3:2])
                2'b00:   m_data_rdata = {28'd0, ctrl};
                2'b01:   m_data_rdata = preset;
                2'b10:   m_data_rdata = count;
                default: m_data_rdata = '0;
            endcase
        end
    end

`ifdef DM_TIMER_BRIDGE_WRITE_LOG_EN
    logic        tmr_log;
    logic [31:0] tmr_log_val;

    assign tmr_log     = tmr_we && (m_data_addr[3:2] != 2'b10);
    assign tmr_log_val = (m_data_addr[3:2] == 2'b00) ? {28'd0, m_data_wdata[3:0]} : m_data_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            if (ram_we)
                $display("@%h: *%h <= %h", m_inst_addr, {m_data_addr[31:2], 2'b00}, ram_merged);
            if (tmr_log)
                $display("@%h: *%h <= %h", m_inst_addr, {m_data_addr[31:2], 2'b00}, tmr_log_val);
        end
    end
`else
    logic unused_inst_addr;
    assign unused_inst_addr = ^m_inst_addr;
`endif

endmodule
